intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Phase sequencer for the Thevenin/Norton intersection. It owns the timing of all nine signal heads: three 3-aspect vehicle heads (TH, NN, NS), three 2-aspect turn arrows and three pedestrian heads. Vehicle sensors extend green time and latched pedestrian pushbuttons insert a walk phase. It runs on the low-frequency oscillator clock and drives the lamp-driver instances with per-head aspect levels.

## Interface
- CLK_PER_MS, 10: clklf cycles per 1 ms tick (10 kHz clock).
- T_MIN_GREEN, 10000: minimum vehicle green, ms.
- T_EXT, 3000: gap time, in ms; green may end once the own-approach sensor has been idle this long.
- T_MAX_GREEN, 30000: green cap under conflicting demand, ms.
- T_YELLOW, 3000: yellow duration, ms.
- T_ALL_RED, 2000: all-red clearance, ms.
- T_PED, 8000: pedestrian walk duration, ms.
- clklf  in  1  system clock, the 10 kHz LF oscillator.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = run; 0 = freeze state, prescaler and all timers.
- sens_th, sens_nn, sens_ns  in  1 each  vehicle presence, asynchronous, active-high.
- btn_th, btn_nn, btn_ns  in  1 each  pedestrian pushbuttons, asynchronous, active-high.
- th_aspect, nn_aspect, ns_aspect  out  2 each  00 red, 01 yellow, 10 green (11 never driven).
- g_th_left, g_nn_left, g_nn_right  out  1 each  turn arrow; 1 = green, 0 = red.
- p_th1, p_th2, p_n  out  1 each  pedestrian head; 1 = walk, 0 = don't walk.
- phase  out  3  current state encoding, for debug.
- ped_pending  out  3  latched requests {n, th2, th1}.

## Operation
- States: RED_INIT(0), TH_GREEN(1), TH_YELLOW(2), RED_A(3), N_GREEN(4), N_YELLOW(5), RED_B(6), PED_WALK(7).
- Reset state is RED_INIT. It lasts T_ALL_RED, then goes to TH_GREEN.
- TH_GREEN -> TH_YELLOW -> RED_A. From RED_A: if any ped_pending, go to PED_WALK with next_n=1; otherwise go to N_GREEN.
- N_GREEN -> N_YELLOW -> RED_B. From RED_B: if any ped_pending, go to PED_WALK with next_n=0; otherwise go to TH_GREEN.
- PED_WALK lasts T_PED. It then enters RED_INIT, which lasts T_ALL_RED and exits to N_GREEN if next_n=1, else to TH_GREEN.
- Output decode, combinational from the state register:
  - TH_GREEN: th_aspect=10 and g_th_left=1.
  - TH_YELLOW: th_aspect=01.
  - N_GREEN: nn_aspect=ns_aspect=10, g_nn_left=g_nn_right=1.
  - N_YELLOW: nn_aspect=ns_aspect=01.
  - PED_WALK: p_th1=p_th2=p_n=1.
  - Every other head in every state is red / don't walk.
- Green termination is evaluated on a tick. Green ends only when all of the following hold:
  - elapsed >= T_MIN_GREEN;
  - conflicting demand exists;
  - gap >= T_EXT or elapsed >= T_MAX_GREEN.
  Without conflicting demand the phase rests in green indefinitely.
- Own sensor: sens_th for TH; sens_nn|sens_ns for N.
- Conflicting demand for TH_GREEN: sens_nn|sens_ns|(|ped_pending). For N_GREEN: sens_th|(|ped_pending).
- gap counter: cleared while the own sensor (synchronized) is 1; otherwise +1 per tick. It saturates at T_EXT.
- elapsed counter: saturates at T_MAX_GREEN. Width is 18 bits for all counters.
- Inputs pass through a 2-flop synchronizer. Buttons are additionally edge-detected; a rising edge sets the matching ped_pending bit.
- All three ped_pending bits clear on entry to PED_WALK. Presses during PED_WALK are ignored.
- Presses are latched while en=0.

## Timing
- Tick: the prescaler counts 0..CLK_PER_MS-1 and ticks on the wrap. The prescaler is cleared on every state entry.
- elapsed is cleared on every state entry and increments on each tick.
- A fixed-duration state of T ms exits on the edge where the tick makes elapsed reach T. It therefore occupies exactly T*CLK_PER_MS cycles.
- Outputs change in the same cycle as the state register.
- Sensor/button-to-logic latency is 2 cycles. A button press must be at least 1 cycle wide after synchronization.
- en=0 holds everything, so each cycle of en=0 lengthens the current state by one cycle.
- reset assertion at any time sets, immediately and asynchronously:
  - state RED_INIT;
  - all aspects 00, arrows 0, peds 0;
  - ped_pending 0, all counters 0, next_n 0.
- Release is synchronous to the next clklf edge.

## Test plan
Parameters for all scenarios: CLK_PER_MS=2, T_MIN_GREEN=5, T_EXT=2, T_MAX_GREEN=10, T_YELLOW=3, T_ALL_RED=2, T_PED=4.
1. Release reset, all inputs 0 -> all heads red for 4 cycles, then th_aspect=10 and g_th_left=1. State stays TH_GREEN for 200 cycles (no demand).
2. sens_nn=1 held from reset release, sens_th=0 -> TH green lasts exactly 10 cycles, yellow 6, all-red 4. Then nn_aspect=ns_aspect=10 with both NN arrows 1.
3. sens_th=1 and sens_ns=1 held -> TH green maxes out at exactly 20 cycles. N green later also lasts 20 cycles.
4. Pulse btn_th (3 cycles) during N_GREEN with sens_th=1 -> ped_pending=001 after 2-3 cycles. Sequence is N_YELLOW 6, RED_B 4, PED_WALK 8 cycles with all walk=1 and ped_pending=000, then RED_INIT 4, then TH_GREEN.
5. en=0 for 50 cycles starting mid TH_YELLOW -> yellow totals 56 cycles and outputs are frozen during the hold.
6. Assert reset mid N_GREEN -> same cycle all aspects 00, arrows 0, ped_pending 000. After release, the sequence repeats scenario 1.

Source files
------------

// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection phase sequencer and its surroundings:
// run enable, sensors and pushbuttons in; lamp aspects and debug state out.
interface intersection_scheduler_if;
  logic       en;
  logic       sens_th, sens_nn, sens_ns;
  logic       btn_th, btn_nn, btn_ns;
  logic [1:0] th_aspect, nn_aspect, ns_aspect;
  logic       g_th_left, g_nn_left, g_nn_right;
  logic       p_th1, p_th2, p_n;
  logic [2:0] phase;
  logic [2:0] ped_pending;

  modport master (
    output en, sens_th, sens_nn, sens_ns, btn_th, btn_nn, btn_ns,
    input  th_aspect, nn_aspect, ns_aspect, g_th_left, g_nn_left, g_nn_right,
    input  p_th1, p_th2, p_n, phase, ped_pending
  );

  modport slave (
    input  en, sens_th, sens_nn, sens_ns, btn_th, btn_nn, btn_ns,
    output th_aspect, nn_aspect, ns_aspect, g_th_left, g_nn_left, g_nn_right,
    output p_th1, p_th2, p_n, phase, ped_pending
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Thevenin/Norton intersection phase sequencer: actuated vehicle greens,
// fixed yellow/all-red clearances and a latched pedestrian walk phase.
module intersection_scheduler #(
  parameter int unsigned CLK_PER_MS  = 10,
  parameter int unsigned T_MIN_GREEN = 10000,
  parameter int unsigned T_EXT       = 3000,
  parameter int unsigned T_MAX_GREEN = 30000,
  parameter int unsigned T_YELLOW    = 3000,
  parameter int unsigned T_ALL_RED   = 2000,
  parameter int unsigned T_PED       = 8000
) (
  input  logic clklf,
  input  logic reset,
  intersection_scheduler_if.slave bus
);
  localparam int CW = 18;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] PRESC_MAX = CW'(CLK_PER_MS - 1);
  localparam logic [CW-1:0] MIN_G     = CW'(T_MIN_GREEN);
  localparam logic [CW-1:0] EXT       = CW'(T_EXT);
  localparam logic [CW-1:0] MAX_G     = CW'(T_MAX_GREEN);
  localparam logic [CW-1:0] YEL       = CW'(T_YELLOW);
  localparam logic [CW-1:0] ALL_RED   = CW'(T_ALL_RED);
  localparam logic [CW-1:0] PED       = CW'(T_PED);

  typedef enum logic [2:0] {
    RED_INIT  = 3'd0, TH_GREEN = 3'd1, TH_YELLOW = 3'd2, RED_A    = 3'd3,
    N_GREEN   = 3'd4, N_YELLOW = 3'd5, RED_B     = 3'd6, PED_WALK = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    btn_prev_q, btn_prev_d, ped_q, ped_d;
  logic [CW-1:0] presc_q, presc_d, elapsed_q, elapsed_d, gap_q, gap_d;
  logic          next_n_q, next_n_d;

  logic          s_th, s_nn, s_ns, tick, own_sens, conflict, green_done, entry;
  logic [2:0]    btn_rise;
  logic [CW-1:0] presc_run, elapsed_run, gap_run;

  always_ff @(posedge clklf or negedge reset) begin
    if (!reset) begin
      state_q    <= RED_INIT;
      sync1_q    <= '0;
      sync2_q    <= '0;
      btn_prev_q <= '0;
      ped_q      <= '0;
      presc_q    <= '0;
      elapsed_q  <= '0;
      gap_q      <= '0;
      next_n_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_prev_q <= btn_prev_d;
      ped_q      <= ped_d;
      presc_q    <= presc_d;
      elapsed_q  <= elapsed_d;
      gap_q      <= gap_d;
      next_n_q   <= next_n_d;
    end
  end

  // Synchronizers and button edge detect keep running while en=0 so presses latch.
  always_comb begin
    sync1_d    = {bus.btn_ns, bus.btn_nn, bus.btn_th, bus.sens_ns, bus.sens_nn, bus.sens_th};
    sync2_d    = sync1_q;
    btn_prev_d = sync2_q[5:3];
  end

  assign s_th     = sync2_q[0];
  assign s_nn     = sync2_q[1];
  assign s_ns     = sync2_q[2];
  assign btn_rise = sync2_q[5:3] & ~btn_prev_q;
  assign tick     = bus.en && (presc_q == PRESC_MAX);

  always_comb begin
    own_sens = 1'b0;
    conflict = 1'b0;
    case (state_q)
      TH_GREEN: begin own_sens = s_th;        conflict = s_nn | s_ns | (|ped_q); end
      N_GREEN:  begin own_sens = s_nn | s_ns; conflict = s_th | (|ped_q);        end
      default:  ;
    endcase
  end

  // Timer values as they stand after this cycle, before any state-entry clear.
  always_comb begin
    presc_run   = presc_q;
    elapsed_run = elapsed_q;
    gap_run     = gap_q;
    if (bus.en) begin
      presc_run = tick ? '0 : presc_q + ONE;
      if (tick && elapsed_q < MAX_G) elapsed_run = elapsed_q + ONE;
      if (own_sens)                  gap_run = '0;
      else if (tick && gap_q < EXT)  gap_run = gap_q + ONE;
    end
  end

  assign green_done = tick && (elapsed_run >= MIN_G) && conflict
                      && ((gap_run >= EXT) || (elapsed_run >= MAX_G));

  always_comb begin
    state_d  = state_q;
    next_n_d = next_n_q;
    case (state_q)
      RED_INIT:  if (tick && elapsed_run == ALL_RED) state_d = next_n_q ? N_GREEN : TH_GREEN;
      TH_GREEN:  if (green_done) state_d = TH_YELLOW;
      TH_YELLOW: if (tick && elapsed_run == YEL) state_d = RED_A;
      RED_A: if (tick && elapsed_run == ALL_RED) begin
        if (|ped_q) begin state_d = PED_WALK; next_n_d = 1'b1; end
        else state_d = N_GREEN;
      end
      N_GREEN:   if (green_done) state_d = N_YELLOW;
      N_YELLOW:  if (tick && elapsed_run == YEL) state_d = RED_B;
      RED_B: if (tick && elapsed_run == ALL_RED) begin
        if (|ped_q) begin state_d = PED_WALK; next_n_d = 1'b0; end
        else state_d = TH_GREEN;
      end
      PED_WALK:  if (tick && elapsed_run == PED) state_d = RED_INIT;
      default:   state_d = RED_INIT;
    endcase
  end

  // Gap is also restarted on entry so it measures idle time within this green only.
  always_comb begin
    entry     = (state_d != state_q);
    presc_d   = entry ? '0 : presc_run;
    elapsed_d = entry ? '0 : elapsed_run;
    gap_d     = entry ? '0 : gap_run;
    if (entry && state_d == PED_WALK) ped_d = '0;
    else if (state_q != PED_WALK)     ped_d = ped_q | btn_rise;
    else                              ped_d = ped_q;
  end

  always_comb begin
    bus.th_aspect  = 2'b00;
    bus.nn_aspect  = 2'b00;
    bus.ns_aspect  = 2'b00;
    bus.g_th_left  = 1'b0;
    bus.g_nn_left  = 1'b0;
    bus.g_nn_right = 1'b0;
    bus.p_th1      = 1'b0;
    bus.p_th2      = 1'b0;
    bus.p_n        = 1'b0;
    case (state_q)
      TH_GREEN:  begin bus.th_aspect = 2'b10; bus.g_th_left = 1'b1; end
      TH_YELLOW: bus.th_aspect = 2'b01;
      N_GREEN: begin
        bus.nn_aspect = 2'b10;
        bus.ns_aspect = 2'b10;
        bus.g_nn_left = 1'b1;
        bus.g_nn_right = 1'b1;
      end
      N_YELLOW:  begin bus.nn_aspect = 2'b01; bus.ns_aspect = 2'b01; end
      PED_WALK:  begin bus.p_th1 = 1'b1; bus.p_th2 = 1'b1; bus.p_n = 1'b1; end
      default:   ;
    endcase
    bus.phase       = state_q;
    bus.ped_pending = ped_q;
  end
endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler using the short-timing parameter
// set; expected phase lengths are hand-computed cycle counts.
module tb_intersection_scheduler;
  logic clklf = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Head vectors: {th, nn, ns, g_th_left, g_nn_left, g_nn_right, p_th1, p_th2, p_n}
  localparam logic [11:0] H_RED  = 12'b00_00_00_000_000;
  localparam logic [11:0] H_TH_G = 12'b10_00_00_100_000;
  localparam logic [11:0] H_TH_Y = 12'b01_00_00_000_000;
  localparam logic [11:0] H_N_G  = 12'b00_10_10_011_000;
  localparam logic [11:0] H_N_Y  = 12'b00_01_01_000_000;
  localparam logic [11:0] H_WALK = 12'b00_00_00_000_111;

  intersection_scheduler_if bus ();

  intersection_scheduler #(
    .CLK_PER_MS(2), .T_MIN_GREEN(5), .T_EXT(2), .T_MAX_GREEN(10),
    .T_YELLOW(3), .T_ALL_RED(2), .T_PED(4)
  ) dut (
    .clklf(clklf),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clklf = ~clklf;

  function automatic logic [11:0] heads();
    return {bus.th_aspect, bus.nn_aspect, bus.ns_aspect, bus.g_th_left, bus.g_nn_left,
            bus.g_nn_right, bus.p_th1, bus.p_th2, bus.p_n};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clklf);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the edge that entered phase ph; counts cycles spent there.
  task automatic run_len(input string tag, input int ph, input int exp, input logic [11:0] hd);
    int n = 0;
    chk({tag, "_phase"}, 32'(bus.phase), 32'(ph));
    chk({tag, "_heads"}, 32'(heads()), 32'(hd));
    while (bus.phase == 3'(ph) && n < exp + 50) begin
      tick(1);
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'(exp));
  endtask

  initial begin
    bus.en = 1'b1;
    bus.sens_th = 1'b0; bus.sens_nn = 1'b0; bus.sens_ns = 1'b0;
    bus.btn_th  = 1'b0; bus.btn_nn  = 1'b0; bus.btn_ns  = 1'b0;
    tick(3);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_heads", 32'(heads()), 32'(H_RED));
    chk("rst_ped", 32'(bus.ped_pending), 32'd0);

    // 1: no demand, TH rests in green
    reset = 1'b1;
    run_len("s1_red_init", 0, 4, H_RED);
    chk("s1_th_green", 32'(heads()), 32'(H_TH_G));
    tick(200);
    chk("s1_rest_phase", 32'(bus.phase), 32'd1);
    chk("s1_rest_heads", 32'(heads()), 32'(H_TH_G));

    // 2: NN demand, TH green ends at minimum
    reset = 1'b0; tick(1); bus.sens_nn = 1'b1; reset = 1'b1;
    run_len("s2_red_init", 0, 4, H_RED);
    run_len("s2_th_green", 1, 10, H_TH_G);
    run_len("s2_th_yellow", 2, 6, H_TH_Y);
    run_len("s2_red_a", 3, 4, H_RED);
    chk("s2_n_green", 32'(heads()), 32'(H_N_G));
    tick(100);
    chk("s2_n_rest", 32'(bus.phase), 32'd4);

    // 3: both approaches occupied, greens max out
    reset = 1'b0; tick(1);
    bus.sens_nn = 1'b0; bus.sens_th = 1'b1; bus.sens_ns = 1'b1;
    reset = 1'b1;
    run_len("s3_red_init", 0, 4, H_RED);
    run_len("s3_th_green", 1, 20, H_TH_G);
    run_len("s3_th_yellow", 2, 6, H_TH_Y);
    run_len("s3_red_a", 3, 4, H_RED);
    run_len("s3_n_green", 4, 20, H_N_G);
    run_len("s3_n_yellow", 5, 6, H_N_Y);
    run_len("s3_red_b", 6, 4, H_RED);
    run_len("s3_th_green2", 1, 20, H_TH_G);
    run_len("s3_th_yellow2", 2, 6, H_TH_Y);
    run_len("s3_red_a2", 3, 4, H_RED);

    // 4: pedestrian press during N green
    chk("s4_in_n_green", 32'(bus.phase), 32'd4);
    bus.btn_th = 1'b1; tick(3); bus.btn_th = 1'b0;
    chk("s4_ped_latched", 32'(bus.ped_pending), 32'b001);
    run_len("s4_n_green_rest", 4, 17, H_N_G);
    run_len("s4_n_yellow", 5, 6, H_N_Y);
    chk("s4_ped_held", 32'(bus.ped_pending), 32'b001);
    run_len("s4_red_b", 6, 4, H_RED);
    chk("s4_ped_cleared", 32'(bus.ped_pending), 32'b000);
    run_len("s4_walk", 7, 8, H_WALK);
    run_len("s4_red_init", 0, 4, H_RED);
    chk("s4_back_th", 32'(bus.phase), 32'd1);
    chk("s4_back_th_heads", 32'(heads()), 32'(H_TH_G));

    // 5: en=0 for 50 cycles inside TH yellow, press latched while frozen
    run_len("s5_th_green", 1, 20, H_TH_G);
    tick(3);
    bus.en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) bus.btn_th = 1'b1;
      if (i == 13) bus.btn_th = 1'b0;
      tick(1);
      chk("s5_hold", 32'({bus.phase, heads()}), 32'({3'd2, H_TH_Y}));
    end
    chk("s5_ped_latched", 32'(bus.ped_pending), 32'b001);
    bus.en = 1'b1;
    run_len("s5_yellow_rest", 2, 3, H_TH_Y);
    run_len("s5_red_a", 3, 4, H_RED);
    chk("s5_ped_cleared", 32'(bus.ped_pending), 32'b000);
    chk("s5_walk_phase", 32'(bus.phase), 32'd7);
    bus.btn_th = 1'b1; tick(3); bus.btn_th = 1'b0;
    run_len("s5_walk_rest", 7, 5, H_WALK);
    chk("s5_walk_press_ignored", 32'(bus.ped_pending), 32'b000);
    run_len("s5_red_init", 0, 4, H_RED);
    chk("s5_to_n_green", 32'(bus.phase), 32'd4);
    chk("s5_to_n_heads", 32'(heads()), 32'(H_N_G));

    // 6: asynchronous reset mid N green
    bus.btn_th = 1'b1; tick(3); bus.btn_th = 1'b0;
    chk("s6_ped_set", 32'(bus.ped_pending), 32'b001);
    #2 reset = 1'b0;
    #1;
    chk("s6_async_phase", 32'(bus.phase), 32'd0);
    chk("s6_async_heads", 32'(heads()), 32'(H_RED));
    chk("s6_async_ped", 32'(bus.ped_pending), 32'b000);
    bus.sens_th = 1'b0; bus.sens_ns = 1'b0;
    @(posedge clklf); #1;
    reset = 1'b1;
    run_len("s6_red_init", 0, 4, H_RED);
    chk("s6_th_green", 32'(heads()), 32'(H_TH_G));
    tick(200);
    chk("s6_rest_phase", 32'(bus.phase), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
